// File: rtl/packet_framer.sv
// Store-and-forward packet framer: buffers one payload, then emits a two-beat header
// (destination address + length) followed by the stored payload.
`timescale 1ns/1ps
module packet_framer #(
    parameter int unsigned max_packet_length = 256,
    parameter int unsigned stream_w          = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [stream_w-1:0] i_stream,
    input  logic                i_valid,
    output logic                i_ready,
    input  logic                i_last,
    input  logic [47:0]         destination_addr,
    output logic [stream_w-1:0] o_stream,
    output logic                o_valid,
    input  logic                o_ready,
    output logic                o_last,
    output logic                error_packet_too_long,
    input  logic                clear_errors
);
    localparam int unsigned AW = $clog2(max_packet_length) + 1;
    localparam int unsigned IW = AW - 1;

    typedef enum logic [2:0] {StFill, StDiscard, StHdr0, StHdr1, StDrain} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [AW-1:0]         r_wr_count;
    logic [AW-1:0]         r_rd_count;
    logic [AW-1:0]         r_len;
    logic [47:0]           r_addr;
    logic                  r_err;
    logic [stream_w-1:0]   r_mem [max_packet_length];

    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_full_beat;
    logic                  w_err_set;
    logic [15:0]           w_len16;

    assign w_in_fire   = i_valid & i_ready;
    assign w_out_fire  = o_valid & o_ready;
    // Current beat is beat number max_packet_length of the packet.
    assign w_full_beat = (r_wr_count == AW'(max_packet_length - 1));
    assign w_err_set   = w_in_fire && (r_state == StFill) && !i_last && w_full_beat;
    assign w_len16     = 16'(r_len);
    assign error_packet_too_long = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StFill;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        i_ready      = 1'b0;
        o_valid      = 1'b0;
        o_last       = 1'b0;
        o_stream     = '0;
        unique case (r_state)
            StFill: begin
                i_ready = 1'b1;
                if (i_valid) begin
                    if (i_last) begin
                        w_state_next = StHdr0;
                    end else if (w_full_beat) begin
                        w_state_next = StDiscard;
                    end
                end
            end
            StDiscard: begin
                i_ready = 1'b1;
                if (i_valid && i_last) begin
                    w_state_next = StHdr0;
                end
            end
            StHdr0: begin
                o_valid  = 1'b1;
                o_stream = stream_w'(r_addr[47:16]);
                if (o_ready) begin
                    w_state_next = StHdr1;
                end
            end
            StHdr1: begin
                o_valid  = 1'b1;
                o_stream = stream_w'({r_addr[15:0], w_len16});
                if (o_ready) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                o_valid  = 1'b1;
                o_stream = r_mem[r_rd_count[IW-1:0]];
                o_last   = (r_rd_count == r_len);
                if (o_ready && o_last) begin
                    w_state_next = StFill;
                end
            end
            default: w_state_next = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_count <= '0;
            r_rd_count <= '0;
            r_len      <= '0;
            r_addr     <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_in_fire) begin
                if (r_state == StFill) begin
                    r_wr_count <= r_wr_count + 1'b1;
                    if (i_last || w_full_beat) begin
                        r_len <= r_wr_count;
                    end
                end
                if (i_last) begin
                    r_addr <= destination_addr;
                end
            end
            if (w_out_fire && o_last) begin
                r_wr_count <= '0;
                r_rd_count <= '0;
            end else if (w_out_fire && (r_state == StDrain)) begin
                r_rd_count <= r_rd_count + 1'b1;
            end
            // A set in the same cycle as a clear wins.
            r_err <= w_err_set | (r_err & ~clear_errors);
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire && (r_state == StFill)) begin
            r_mem[r_wr_count[IW-1:0]] <= i_stream;
        end
    end
endmodule

// File: tb/tb_packet_framer.sv
// Bench for packet_framer: queue-based frame model checked every cycle, plus directed
// literal expectations for header encoding, latency, overflow and reset.
`timescale 1ns/1ps
module tb_packet_framer;
    localparam int MAX = 256;
    localparam int SW  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [SW-1:0] i_stream = '0;
    logic          i_valid = 1'b0;
    logic          i_ready;
    logic          i_last = 1'b0;
    logic [47:0]   destination_addr = '0;
    logic [SW-1:0] o_stream;
    logic          o_valid;
    logic          o_ready = 1'b1;
    logic          o_last;
    logic          error_packet_too_long;
    logic          clear_errors = 1'b0;

    packet_framer #(.max_packet_length(MAX), .stream_w(SW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_stream              (i_stream),
        .i_valid               (i_valid),
        .i_ready               (i_ready),
        .i_last                (i_last),
        .destination_addr      (destination_addr),
        .o_stream              (o_stream),
        .o_valid               (o_valid),
        .o_ready               (o_ready),
        .o_last                (o_last),
        .error_packet_too_long (error_packet_too_long),
        .clear_errors          (clear_errors)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: expected output beats and the packet being collected.
    logic [SW-1:0] exp_q[$];
    bit            last_q[$];
    logic [SW-1:0] pkt_q[$];
    int            pkt_n = 0;
    bit            err_m = 0;
    logic [SW-1:0] out_log[$];
    bit            last_log[$];
    bit            stall_prev = 0;
    logic [SW-1:0] prev_s = '0;
    bit            prev_l = 0;
    bit            prev_ov = 0;
    bit            fill_due = 0;
    int            cyc = 0;
    int            last_acc_cyc = 0;
    int            first_ov_cyc = 0;
    bit            rnd_ready = 0;

    always @(negedge clk) begin
        bit set;
        int len;
        cyc++;
        if (!rst) begin
            exp_q.delete();
            last_q.delete();
            pkt_q.delete();
            pkt_n      = 0;
            err_m      = 0;
            stall_prev = 0;
            prev_ov    = 0;
            fill_due   = 0;
        end else begin
            chk("err_flag", error_packet_too_long, err_m);
            chk("o_valid", o_valid, exp_q.size() != 0);
            chk("io_overlap", i_ready & o_valid, 0);
            if (fill_due) begin
                chk("ready_after_frame", i_ready, 1);
                fill_due = 0;
            end
            if (stall_prev) begin
                chk("stall_valid", o_valid, 1);
                chk("stall_stream", o_stream, prev_s);
                chk("stall_last", o_last, prev_l);
            end
            if (o_valid && !prev_ov) first_ov_cyc = cyc;
            if (o_valid && exp_q.size() != 0) begin
                chk("o_stream", o_stream, exp_q[0]);
                chk("o_last", o_last, last_q[0]);
                if (o_ready) begin
                    out_log.push_back(o_stream);
                    last_log.push_back(o_last);
                    if (last_q[0]) fill_due = 1;
                    void'(exp_q.pop_front());
                    void'(last_q.pop_front());
                end
            end
            stall_prev = o_valid && !o_ready;
            prev_s     = o_stream;
            prev_l     = o_last;
            prev_ov    = o_valid;

            set = 0;
            if (i_valid && i_ready) begin
                pkt_n++;
                if (pkt_n <= MAX) pkt_q.push_back(i_stream);
                if (pkt_n == MAX && !i_last) set = 1;
                if (i_last) begin
                    len = pkt_q.size() - 1;
                    exp_q.push_back(SW'(destination_addr[47:16]));
                    last_q.push_back(0);
                    exp_q.push_back(SW'({destination_addr[15:0], 16'(len)}));
                    last_q.push_back(0);
                    for (int k = 0; k < pkt_q.size(); k++) begin
                        exp_q.push_back(pkt_q[k]);
                        last_q.push_back(k == pkt_q.size() - 1);
                    end
                    pkt_q.delete();
                    pkt_n        = 0;
                    last_acc_cyc = cyc;
                end
            end
            err_m = set ? 1'b1 : (clear_errors ? 1'b0 : err_m);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            o_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    task automatic send_pkt(int n, logic [47:0] addr, int gap, int clr_beat, logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            int w;
            while (gap > 0 && $urandom_range(99) < gap) begin
                i_valid      = 0;
                clear_errors = 0;
                @(posedge clk);
                #1;
            end
            i_valid          = 1;
            i_stream         = (base != 0) ? base + 32'(i) : $urandom;
            i_last           = (i == n - 1);
            destination_addr = (i == n - 1) ? addr : {16'($urandom), $urandom};
            clear_errors     = (i == clr_beat);
            w = 0;
            while (!i_ready && w < 100) begin
                @(posedge clk);
                #1;
                w++;
            end
            if (!i_ready) chk("i_ready_timeout", i_ready, 1);
            @(posedge clk);
            #1;
        end
        i_valid      = 0;
        i_last       = 0;
        clear_errors = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drained", exp_q.size(), 0);
    endtask

    task automatic clr_logs();
        out_log.delete();
        last_log.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [47:0] a;
        int          w;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_last", o_last, 0);
        chk("rst_err", error_packet_too_long, 0);
        rst = 1;
        @(negedge clk);
        chk("ready_after_rst", i_ready, 1);
        @(posedge clk);
        #1;

        // Three beats A,B,C.
        clr_logs();
        send_pkt(3, 48'h001122334455, 0, -1, 32'hAAAA0000);
        wait_idle();
        chk("abc_n", out_log.size(), 5);
        chk("abc_0", out_log[0], 32'h00112233);
        chk("abc_1", out_log[1], 32'h44550002);
        chk("abc_2", out_log[2], 32'hAAAA0000);
        chk("abc_3", out_log[3], 32'hAAAA0001);
        chk("abc_4", out_log[4], 32'hAAAA0002);
        chk("abc_last", {last_log[0], last_log[1], last_log[2], last_log[3], last_log[4]}, 5'b00001);
        chk("abc_latency", first_ov_cyc - last_acc_cyc, 1);

        // Single beat D.
        clr_logs();
        send_pkt(1, 48'h001122334455, 0, -1, 32'hD0D0D0D0);
        wait_idle();
        chk("d_n", out_log.size(), 3);
        chk("d_0", out_log[0], 32'h00112233);
        chk("d_1", out_log[1], 32'h44550000);
        chk("d_2", out_log[2], 32'hD0D0D0D0);
        chk("d_last", {last_log[0], last_log[1], last_log[2]}, 3'b001);

        // 20 beats under random backpressure.
        rnd_ready = 1;
        clr_logs();
        send_pkt(20, 48'hA1B2C3D4E5F6, 30, -1, 0);
        wait_idle();
        chk("n20_beats", out_log.size(), 22);
        chk("n20_len", out_log[1], 32'hE5F60013);

        for (int p = 0; p < 6; p++) begin
            a = {16'($urandom), $urandom};
            send_pkt(int'($urandom_range(40, 1)), a, 20, -1, 0);
            wait_idle();
        end
        rnd_ready = 0;

        // Exactly max length, then over-length.
        clr_logs();
        send_pkt(MAX, 48'h0000CAFE1234, 0, -1, 0);
        wait_idle();
        chk("full_n", out_log.size(), MAX + 2);
        chk("full_len", out_log[1][15:0], 16'h00FF);
        chk("full_err", error_packet_too_long, 0);

        clr_logs();
        send_pkt(MAX + 4, 48'h0000CAFE1234, 0, -1, 0);
        wait_idle();
        chk("over_n", out_log.size(), MAX + 2);
        chk("over_len", out_log[1][15:0], 16'h00FF);
        chk("over_err", error_packet_too_long, 1);

        clear_errors = 1;
        @(posedge clk);
        #1;
        clear_errors = 0;
        chk("clear_err", error_packet_too_long, 0);

        // Clear coincides with the overflowing beat: set wins.
        send_pkt(MAX + 2, 48'h123456789ABC, 0, MAX - 1, 0);
        chk("set_wins", error_packet_too_long, 1);
        wait_idle();
        clear_errors = 1;
        @(posedge clk);
        #1;
        clear_errors = 0;
        chk("clear_after", error_packet_too_long, 0);

        // Reset in the middle of draining.
        clr_logs();
        send_pkt(10, 48'h0102030405AA, 0, -1, 0);
        w = 0;
        while (out_log.size() < 4 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        #1;
        rst = 0;
        #1;
        chk("midrst_o_valid", o_valid, 0);
        chk("midrst_o_last", o_last, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        @(negedge clk);
        chk("midrst_ready", i_ready, 1);
        @(posedge clk);
        #1;
        clr_logs();
        send_pkt(5, 48'h665544332211, 0, -1, 32'hBEEF0000);
        wait_idle();
        chk("post_n", out_log.size(), 7);
        chk("post_0", out_log[0], 32'h66554433);
        chk("post_1", out_log[1], 32'h22110004);
        chk("post_2", out_log[2], 32'hBEEF0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
